flit_queue: RTL and testbench
=============================

# flit_queue

Timestamped flit FIFO (FQ) that buffers flits arriving from the upstream link/injection side and presents the head flit, its timestamp and a valid flag to the downstream flit-out interface and router. It provides show-ahead head visibility, full/empty/occupancy status, a one-cycle credit pulse per dequeue, and sticky error flags for protocol violations. Timestamp arithmetic is modular over `TS_WIDTH` bits, consistent with the rest of the simulation-time datapath.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `FLIT_WIDTH`, 36: flit payload width in bits.
- `CNT_WIDTH`, log2(DEPTH)+1: occupancy counter width; derived, not overridden.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `enqueue`  in  1  write `in_flit` / `in_timestamp` this cycle.
- `in_flit`  in  FLIT_WIDTH  incoming flit payload.
- `in_timestamp`  in  `TS_WIDTH`  incoming flit timestamp.
- `dequeue`  in  1  pop head entry this cycle.
- `sim_time`  in  `TS_WIDTH`  current simulation time; used only by the late check.
- `flit_valid`  out  1  head entry present.
- `flit`  out  FLIT_WIDTH  head payload; don't-care when `flit_valid`=0.
- `flit_timestamp`  out  `TS_WIDTH`  head timestamp.
- `count`  out  CNT_WIDTH  current occupancy.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `credit`  out  1  one-cycle pulse per accepted dequeue.
- `overflow`  out  1  sticky: enqueue while full without dequeue.
- `underflow`  out  1  sticky: dequeue while empty.
- `late_err`  out  1  sticky: late arrival (config-dependent).

## Operation
- Storage: DEPTH × (FLIT_WIDTH+`TS_WIDTH`) register array; write pointer `wr_ptr`, read pointer `rd_ptr`, each log2(DEPTH) bits, wrapping naturally.
- Head outputs are a combinational read of entry `rd_ptr`; `flit_valid` = ~`empty`.
- Accepted enqueue: `enqueue` & (~`full` | `dequeue`). Writes entry `wr_ptr`, increments `wr_ptr`.
- Accepted dequeue: `dequeue` & ~`empty`. Increments `rd_ptr`, pulses `credit` next cycle.
- `count` += accepted enqueue, −= accepted dequeue; simultaneous accept leaves `count` unchanged.
- Full with `enqueue`+`dequeue`: both accepted; new flit lands in freed slot.
- Empty with `enqueue`+`dequeue`: enqueue accepted, dequeue rejected and `underflow` set (no bypass).
- Rejected enqueue (full, no dequeue): flit dropped, `overflow` set, state otherwise unchanged.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, immediate): pointers 0, `count`=0, `empty`=1, `full`=0, `flit_valid`=0, `credit`=0, all error flags 0.
- Enqueue-to-head latency: 1 cycle (flit visible at head the cycle after the enqueue edge when queue was empty).
- Dequeue: head advances at that edge; next entry visible the following cycle, zero bubbles under back-to-back dequeue.
- `credit` registered: asserted the cycle after the accepted dequeue, for exactly one cycle per dequeue.
- Reset deasserted mid-stream: all contents discarded; first enqueue after release behaves as into an empty queue.

## Configuration
- `FQ_LATE_CHECK_EN` defined: on accepted enqueue, compute `d` = `in_timestamp` − `sim_time` modulo 2^`TS_WIDTH`; if MSB of `d` is 1 (flit timestamp earlier than current time), set `late_err` on the next edge. Flit is still stored.
- Undefined: no comparator is built, `late_err` is tied 0, `sim_time` is unused.

## Structure
- `TS_WIDTH` from the shared `const.v`; add a `FQ_DEPTH_DEFAULT` constant there.
- One sub-module, `fq_ts_late_check`: the modular late-arrival comparator, instantiated only under `FQ_LATE_CHECK_EN`.

## Test plan
- Reset, then enqueue flit 0x0A5 with ts=5 → next cycle `flit_valid`=1, `flit`=0x0A5, `flit_timestamp`=5, `count`=1.
- Enqueue 8 flits (DEPTH=8) → `full`=1; 9th enqueue without dequeue → dropped, `overflow`=1, `count`=8, head unchanged.
- Full queue with enqueue+dequeue same cycle → `count` stays 8, head advances, new flit appears last; one `credit` pulse.
- Dequeue on empty → `underflow`=1, `count`=0, no `credit`.
- Enqueue 20 flits with interleaved dequeues to wrap pointers → output order equals input order and every timestamp is preserved.
- With `FQ_LATE_CHECK_EN`: `sim_time`=20, enqueue ts=18 → `late_err`=1; enqueue ts=21 → no flag; at `TS_WIDTH` wrap, `sim_time`=2^`TS_WIDTH`−1 with ts=1 → no flag.

Source files
------------

// File: rtl/flit_queue_pkg.sv
// Shared constants for the flit queue slice: simulation-time width and default depth.
// Optional feature macro used by this slice: FQ_LATE_CHECK_EN (late-arrival flag).
package flit_queue_pkg;

  // Width of all simulation-time / timestamp values in the datapath.
  localparam int TS_WIDTH = 16;

  // Default number of queue entries (power of two, at least 2).
  localparam int FQ_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/flit_queue_ts_late_check.sv
// fq_ts_late_check: modular late-arrival comparator.
// A timestamp is late when (in_timestamp - sim_time) mod 2^TS_WIDTH has its MSB
// set, i.e. the flit is stamped earlier than the current time within half the
// timestamp range. Only instantiated when FQ_LATE_CHECK_EN is defined.
module fq_ts_late_check #(
  parameter int TS_WIDTH = 16
) (
  input  logic [TS_WIDTH-1:0] in_timestamp,
  input  logic [TS_WIDTH-1:0] sim_time,
  output logic                late
);

  logic [TS_WIDTH-1:0] ts_diff;

  // Wrapping difference; its sign bit tells whether the flit is behind sim_time.
  always_comb begin
    ts_diff = in_timestamp - sim_time;
    late    = ts_diff[TS_WIDTH-1];
  end

endmodule

// File: rtl/flit_queue.sv
// flit_queue: timestamped show-ahead flit FIFO with occupancy status, a credit
// pulse per dequeue and sticky protocol-error flags.
// Optional feature: define FQ_LATE_CHECK_EN to build the late-arrival comparator
// that drives late_err; otherwise late_err is tied low and sim_time is ignored.
module flit_queue
  import flit_queue_pkg::*;
#(
  parameter  int DEPTH      = FQ_DEPTH_DEFAULT,
  parameter  int FLIT_WIDTH = 36,
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enqueue,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic [TS_WIDTH-1:0]   in_timestamp,
  input  logic                  dequeue,
  input  logic [TS_WIDTH-1:0]   sim_time,
  output logic                  flit_valid,
  output logic [FLIT_WIDTH-1:0] flit,
  output logic [TS_WIDTH-1:0]   flit_timestamp,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  credit,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  late_err
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [FLIT_WIDTH-1:0] flit_mem [DEPTH];
  logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  enq_accept;
  logic                  deq_accept;

  // Status, acceptance and show-ahead head read.
  always_comb begin
    full           = (count == CNT_WIDTH'(DEPTH));
    empty          = (count == '0);
    flit_valid     = ~empty;
    // A full queue still accepts a write when the head is popped in the same cycle.
    enq_accept     = enqueue & (~full | dequeue);
    // No bypass: a dequeue into an empty queue is always rejected.
    deq_accept     = dequeue & ~empty;
    flit           = flit_mem[rd_ptr];
    flit_timestamp = ts_mem[rd_ptr];
  end

  // Storage array; contents need no reset because pointers and count define validity.
  always_ff @(posedge clock) begin
    if (enq_accept) begin
      flit_mem[wr_ptr] <= in_flit;
      ts_mem[wr_ptr]   <= in_timestamp;
    end
  end

  // Pointers, occupancy, credit pulse and sticky protocol flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      credit    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enq_accept) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (deq_accept) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({enq_accept, deq_accept})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      credit <= deq_accept;
      if (enqueue & full & ~dequeue) overflow  <= 1'b1;
      if (dequeue & empty)           underflow <= 1'b1;
    end
  end

`ifdef FQ_LATE_CHECK_EN
  logic ts_late;

  fq_ts_late_check #(
    .TS_WIDTH (TS_WIDTH)
  ) u_late_check (
    .in_timestamp (in_timestamp),
    .sim_time     (sim_time),
    .late         (ts_late)
  );

  // Late flag is sticky and only considers flits that were actually stored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      late_err <= 1'b0;
    end else if (enq_accept & ts_late) begin
      late_err <= 1'b1;
    end
  end
`else
  logic unused_sim_time;

  assign unused_sim_time = ^sim_time;
  assign late_err        = 1'b0;
`endif

endmodule

// File: tb/tb_flit_queue.sv
// Self-checking bench for flit_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the FIFO behaviour.
module tb_flit_queue;
  import flit_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = 36;
  localparam int CW    = 4;
  localparam int EW    = FW + TS_WIDTH;

  logic                clock = 1'b0;
  logic                reset;
  logic                enqueue;
  logic [FW-1:0]       in_flit;
  logic [TS_WIDTH-1:0] in_timestamp;
  logic                dequeue;
  logic [TS_WIDTH-1:0] sim_time;
  logic                flit_valid;
  logic [FW-1:0]       flit;
  logic [TS_WIDTH-1:0] flit_timestamp;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                credit;
  logic                overflow;
  logic                underflow;
  logic                late_err;

  int checks = 0;
  int passed = 0;

  logic [EW-1:0] mq[$];
  logic          m_credit;
  logic          m_ovf;
  logic          m_unf;
  logic          m_late;

  flit_queue #(
    .DEPTH      (DEPTH),
    .FLIT_WIDTH (FW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enqueue        (enqueue),
    .in_flit        (in_flit),
    .in_timestamp   (in_timestamp),
    .dequeue        (dequeue),
    .sim_time       (sim_time),
    .flit_valid     (flit_valid),
    .flit           (flit),
    .flit_timestamp (flit_timestamp),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .credit         (credit),
    .overflow       (overflow),
    .underflow      (underflow),
    .late_err       (late_err)
  );

  always #5 clock = ~clock;

  function automatic logic ts_behind(input logic [TS_WIDTH-1:0] ts, input logic [TS_WIDTH-1:0] now);
    logic [TS_WIDTH-1:0] lag;
    lag = now - ts;
    return (lag != 0) && (int'(lag) <= (1 << (TS_WIDTH - 1)));
  endfunction

  // Apply one cycle of stimulus, then advance the model to match the edge.
  task automatic step(input logic en, input logic [FW-1:0] f, input logic [TS_WIDTH-1:0] ts,
                      input logic de);
    bit e_ok;
    bit d_ok;
    enqueue      = en;
    in_flit      = f;
    in_timestamp = ts;
    dequeue      = de;
    d_ok = de && (mq.size() != 0);
    e_ok = en && ((mq.size() < DEPTH) || de);
    @(posedge clock);
    #1;
    if (d_ok) void'(mq.pop_front());
    if (e_ok) mq.push_back({f, ts});
    m_credit = d_ok;
    if (en && !e_ok) m_ovf = 1'b1;
    if (de && !d_ok) m_unf = 1'b1;
`ifdef FQ_LATE_CHECK_EN
    if (e_ok && ts_behind(ts, sim_time)) m_late = 1'b1;
`endif
    enqueue = 1'b0;
    dequeue = 1'b0;
  endtask

  task automatic do_reset();
    enqueue  = 1'b0;
    dequeue  = 1'b0;
    reset    = 1'b0;
    #2;
    mq.delete();
    m_credit = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_late   = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic test_reset();
    enqueue = 1'b0; dequeue = 1'b0; in_flit = '0; in_timestamp = '0; sim_time = '0;
    reset = 1'b0;
    #3;
    checks++;
    if ({count, empty, full, flit_valid} !== {4'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_status got cnt=%0d e=%b f=%b v=%b want cnt=0 e=1 f=0 v=0",
               count, empty, full, flit_valid);
    else passed++;
    checks++;
    if ({credit, overflow, underflow, late_err} !== 4'b0000)
      $display("FAIL reset_flags got cr=%b ov=%b un=%b late=%b want all 0",
               credit, overflow, underflow, late_err);
    else passed++;
    #4;
    do_reset();
  endtask

  task automatic test_first_enqueue();
    do_reset();
    step(1'b1, 36'h0A5, 16'd5, 1'b0);
    checks++;
    if ({flit_valid, flit, flit_timestamp, count} !== {1'b1, 36'h0A5, 16'd5, 4'd1})
      $display("FAIL first_enq got v=%b flit=%h ts=%0d cnt=%0d want v=1 flit=0a5 ts=5 cnt=1",
               flit_valid, flit, flit_timestamp, count);
    else passed++;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, FW'($urandom()), TS_WIDTH'($urandom()), 1'b0);
    checks++;
    if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0})
      $display("FAIL fill got full=%b cnt=%0d ov=%b want full=1 cnt=8 ov=0", full, count, overflow);
    else passed++;
    step(1'b1, 36'hDEAD, 16'hBEEF, 1'b0);
    checks++;
    if ({overflow, count, full} !== {m_ovf, 4'd8, 1'b1})
      $display("FAIL overflow got ov=%b cnt=%0d full=%b want ov=%b cnt=8 full=1",
               overflow, count, full, m_ovf);
    else passed++;
    checks++;
    if ({flit, flit_timestamp} !== mq[0])
      $display("FAIL overflow_head got %h want %h", {flit, flit_timestamp}, mq[0]);
    else passed++;
  endtask

  task automatic test_full_simul();
    logic [EW-1:0] newest;
    newest = {36'h123456789, 16'h4242};
    step(1'b1, newest[EW-1:TS_WIDTH], newest[TS_WIDTH-1:0], 1'b1);
    checks++;
    if ({count, credit, full} !== {4'd8, 1'b1, 1'b1})
      $display("FAIL full_simul got cnt=%0d cr=%b full=%b want cnt=8 cr=1 full=1", count, credit, full);
    else passed++;
    checks++;
    if ({flit, flit_timestamp} !== mq[0])
      $display("FAIL full_simul_head got %h want %h", {flit, flit_timestamp}, mq[0]);
    else passed++;
    step(1'b0, '0, '0, 1'b0);
    checks++;
    if (credit !== 1'b0)
      $display("FAIL credit_single got %b want 0", credit);
    else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if ({flit_valid, flit, flit_timestamp} !== {1'b1, mq[0]})
        $display("FAIL drain_order[%0d] got v=%b %h want %h", i, flit_valid, {flit, flit_timestamp}, mq[0]);
      else passed++;
      if (i == DEPTH - 1) begin
        checks++;
        if ({flit, flit_timestamp} !== newest)
          $display("FAIL newest_last got %h want %h", {flit, flit_timestamp}, newest);
        else passed++;
      end
      step(1'b0, '0, '0, 1'b1);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if ({underflow, count, credit, empty} !== {m_unf, 4'd0, 1'b0, 1'b1})
      $display("FAIL underflow got un=%b cnt=%0d cr=%b e=%b want un=%b cnt=0 cr=0 e=1",
               underflow, count, credit, empty, m_unf);
    else passed++;
    do_reset();
    step(1'b1, 36'h777, 16'd9, 1'b1);
    checks++;
    if ({underflow, count, credit, flit, flit_timestamp} !== {1'b1, 4'd1, 1'b0, 36'h777, 16'd9})
      $display("FAIL empty_simul got un=%b cnt=%0d cr=%b flit=%h ts=%0d want un=1 cnt=1 cr=0 flit=777 ts=9",
               underflow, count, credit, flit, flit_timestamp);
    else passed++;
  endtask

  task automatic test_wrap_order();
    logic [EW-1:0] sent[$];
    int            rcv;
    int            cyc;
    bit            en;
    bit            de;
    logic [EW-1:0] e;
    do_reset();
    rcv = 0;
    cyc = 0;
    while ((rcv < 20) && (cyc < 400)) begin
      en = (sent.size() < 20) && (mq.size() < DEPTH) && ($urandom_range(0, 99) < 70);
      de = (mq.size() != 0) && ($urandom_range(0, 99) < 50);
      e  = {FW'($urandom()), TS_WIDTH'($urandom())};
      if (de) begin
        checks++;
        if ({flit, flit_timestamp} !== sent[rcv])
          $display("FAIL wrap_order[%0d] got %h want %h", rcv, {flit, flit_timestamp}, sent[rcv]);
        else passed++;
        rcv++;
      end
      if (en) sent.push_back(e);
      step(en, e[EW-1:TS_WIDTH], e[TS_WIDTH-1:0], de);
      cyc++;
    end
    checks++;
    if (rcv != 20)
      $display("FAIL wrap_done got %0d flits want 20", rcv);
    else passed++;
  endtask

  task automatic test_random();
    bit en;
    bit de;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 99) < 55);
      de = ($urandom_range(0, 99) < 45);
      step(en, FW'($urandom()), TS_WIDTH'($urandom()), de);
      checks++;
      if ({count, full, empty, flit_valid} !==
          {CW'(mq.size()), mq.size() == DEPTH, mq.size() == 0, mq.size() != 0})
        $display("FAIL rand_status[%0d] got cnt=%0d f=%b e=%b v=%b want cnt=%0d",
                 i, count, full, empty, flit_valid, mq.size());
      else passed++;
      checks++;
      if ({credit, overflow, underflow} !== {m_credit, m_ovf, m_unf})
        $display("FAIL rand_flags[%0d] got cr=%b ov=%b un=%b want cr=%b ov=%b un=%b",
                 i, credit, overflow, underflow, m_credit, m_ovf, m_unf);
      else passed++;
      if (mq.size() != 0) begin
        checks++;
        if ({flit, flit_timestamp} !== mq[0])
          $display("FAIL rand_head[%0d] got %h want %h", i, {flit, flit_timestamp}, mq[0]);
        else passed++;
      end
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, FW'(i + 1), TS_WIDTH'(i), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    reset = 1'b0;
    #2;
    checks++;
    if ({count, empty, credit} !== {4'd0, 1'b1, 1'b0})
      $display("FAIL midreset got cnt=%0d e=%b cr=%b want cnt=0 e=1 cr=0", count, empty, credit);
    else passed++;
    do_reset();
    step(1'b1, 36'hABC, 16'd77, 1'b0);
    checks++;
    if ({count, flit, flit_timestamp} !== {4'd1, 36'hABC, 16'd77})
      $display("FAIL post_reset got cnt=%0d flit=%h ts=%0d want cnt=1 flit=abc ts=77",
               count, flit, flit_timestamp);
    else passed++;
  endtask

  task automatic test_late();
    logic [TS_WIDTH-1:0] now_v[3];
    logic [TS_WIDTH-1:0] ts_v[3];
    now_v[0] = 16'd20;     ts_v[0] = 16'd18;
    now_v[1] = 16'd20;     ts_v[1] = 16'd21;
    now_v[2] = 16'hFFFF;   ts_v[2] = 16'd1;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      sim_time = now_v[k];
      step(1'b1, FW'(k), ts_v[k], 1'b0);
      checks++;
      if (late_err !== m_late)
        $display("FAIL late[%0d] now=%0d ts=%0d got %b want %b", k, now_v[k], ts_v[k], late_err, m_late);
      else passed++;
      checks++;
      if ({count, flit_timestamp} !== {4'd1, ts_v[k]})
        $display("FAIL late_stored[%0d] got cnt=%0d ts=%0d want cnt=1 ts=%0d",
                 k, count, flit_timestamp, ts_v[k]);
      else passed++;
    end
    sim_time = '0;
  endtask

  initial begin
    test_reset();
    test_first_enqueue();
    test_fill_overflow();
    test_full_simul();
    test_underflow();
    test_wrap_order();
    test_random();
    test_midstream_reset();
    test_late();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no completion want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
